sdram_burst_master: RTL and testbench

- User-side initiator for the SDRAM controller's write/read user ports.
- Accepts a streaming write source into an internal FWFT FIFO and issues fixed-length write bursts at auto-incrementing addresses.
- When enabled, issues read bursts over the written region and streams the returned data out.
- Sits between application logic (e.g. UART RX/TX paths) and sdram_ctrl, on the 100 MHz controller clock.

---
 rtl/sdram_master_pkg.sv | 14 +
 rtl/sdram_wr_fifo.sv | 53 +++++
 rtl/sdram_burst_master.sv | 157 +++++++++++++++
 tb/tb_sdram_burst_master.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_master_pkg.sv
// Shared types and defaults for the SDRAM burst master: FSM encoding and width defaults.
package sdram_master_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 24;
    localparam int BLEN_W     = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        RD   = 2'd2
    } state_t;

endpackage

// File: rtl/sdram_wr_fifo.sv
// Synchronous first-word-fall-through FIFO; head is valid whenever not empty and reads as 0 when empty.
module sdram_wr_fifo #(
    parameter  int DEPTH = 32,
    parameter  int WIDTH = 16,
    localparam int PW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [PW:0]      count,
    output logic             full,
    output logic             empty
);

    localparam logic [PW:0] DEPTH_CNT = (PW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == DEPTH_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/sdram_burst_master.sv
// Buffers a write stream and issues fixed-length SDRAM write bursts, then reads the written region back
// in the same order when enabled. Address pointers wrap to BASE_ADDR after SPAN_BURSTS bursts.
module sdram_burst_master
    import sdram_master_pkg::*;
#(
    parameter int                BURST_LEN   = 10,
    parameter int                DATA_W      = DATA_W_DEF,
    parameter int                ADDR_W      = ADDR_W_DEF,
    parameter int                FIFO_DEPTH  = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
    parameter int                SPAN_BURSTS = 64
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              init_end,
    input  logic              src_valid,
    input  logic [DATA_W-1:0] src_data,
    output logic              src_ready,
    input  logic              rd_run,
    output logic              snk_valid,
    output logic [DATA_W-1:0] snk_data,
    output logic              ovf,
    output logic              sdram_wr_req,
    output logic [ADDR_W-1:0] sdram_wr_addr,
    output logic [BLEN_W-1:0] wr_burst_len,
    output logic [DATA_W-1:0] sdram_data_in,
    input  logic              sdram_wr_ack,
    output logic              sdram_rd_req,
    output logic [ADDR_W-1:0] sdram_rd_addr,
    output logic [BLEN_W-1:0] rd_burst_len,
    input  logic [DATA_W-1:0] sdram_data_out,
    input  logic              sdram_rd_ack,
    output logic [7:0]        stored_bursts
);

    localparam int                CW        = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0]     BL_CNT    = CW'(BURST_LEN);
    localparam logic [BLEN_W-1:0] LAST_ACK  = BLEN_W'(BURST_LEN - 1);
    localparam logic [7:0]        SPAN_B    = 8'(SPAN_BURSTS);
    localparam logic [7:0]        LAST_IDX  = 8'(SPAN_BURSTS - 1);
    localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(BURST_LEN);

    state_t            state;
    logic [BLEN_W-1:0] ack_cnt;
    logic [7:0]        wr_idx;
    logic [7:0]        rd_idx;
    logic [CW-1:0]     fifo_count;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_pop;
    logic              wr_go;
    logic              rd_go;

    assign wr_burst_len = BLEN_W'(BURST_LEN);
    assign rd_burst_len = BLEN_W'(BURST_LEN);
    assign src_ready    = !fifo_full;
    assign fifo_pop     = (state == WR) && sdram_wr_ack;
    assign wr_go        = (fifo_count >= BL_CNT) && (stored_bursts < SPAN_B);
    assign rd_go        = rd_run && (stored_bursts != 8'd0);

    sdram_wr_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W)
    ) u_fifo (
        .clk       (sys_clk),
        .rst       (sys_rst),
        .push      (src_valid),
        .push_data (src_data),
        .pop       (fifo_pop),
        .head      (sdram_data_in),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            ovf <= 1'b0;
        end else if (src_valid && fifo_full) begin
            ovf <= 1'b1;
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state         <= IDLE;
            ack_cnt       <= '0;
            wr_idx        <= '0;
            rd_idx        <= '0;
            sdram_wr_req  <= 1'b0;
            sdram_rd_req  <= 1'b0;
            sdram_wr_addr <= BASE_ADDR;
            sdram_rd_addr <= BASE_ADDR;
            stored_bursts <= '0;
            snk_valid     <= 1'b0;
            snk_data      <= '0;
        end else begin
            snk_valid <= 1'b0;
            case (state)
                IDLE: begin
                    // Write wins so the FIFO drains before it can fill and drop data.
                    if (init_end) begin
                        if (wr_go) begin
                            state        <= WR;
                            sdram_wr_req <= 1'b1;
                        end else if (rd_go) begin
                            state        <= RD;
                            sdram_rd_req <= 1'b1;
                        end
                    end
                end
                WR: begin
                    if (sdram_wr_ack) begin
                        if (ack_cnt == LAST_ACK) begin
                            ack_cnt       <= '0;
                            sdram_wr_req  <= 1'b0;
                            stored_bursts <= stored_bursts + 8'd1;
                            state         <= IDLE;
                            if (wr_idx == LAST_IDX) begin
                                wr_idx        <= '0;
                                sdram_wr_addr <= BASE_ADDR;
                            end else begin
                                wr_idx        <= wr_idx + 8'd1;
                                sdram_wr_addr <= sdram_wr_addr + ADDR_STEP;
                            end
                        end else begin
                            ack_cnt <= ack_cnt + 1'b1;
                        end
                    end
                end
                RD: begin
                    if (sdram_rd_ack) begin
                        snk_valid <= 1'b1;
                        snk_data  <= sdram_data_out;
                        if (ack_cnt == LAST_ACK) begin
                            ack_cnt       <= '0;
                            sdram_rd_req  <= 1'b0;
                            stored_bursts <= stored_bursts - 8'd1;
                            state         <= IDLE;
                            if (rd_idx == LAST_IDX) begin
                                rd_idx        <= '0;
                                sdram_rd_addr <= BASE_ADDR;
                            end else begin
                                rd_idx        <= rd_idx + 8'd1;
                                sdram_rd_addr <= sdram_rd_addr + ADDR_STEP;
                            end
                        end else begin
                            ack_cnt <= ack_cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_burst_master.sv
// Bench for sdram_burst_master: queue-based reference model checked every cycle, directed scenarios plus random traffic.
module tb_sdram_burst_master;

    localparam int BL    = 10;
    localparam int DW    = 16;
    localparam int AW    = 24;
    localparam int DEPTH = 32;
    localparam int SPAN  = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          init_end = 1'b0;
    logic          src_valid = 1'b0;
    logic [DW-1:0] src_data = '0;
    logic          rd_run = 1'b0;
    logic          wr_ack = 1'b0;
    logic          rd_ack = 1'b0;
    logic [DW-1:0] sdram_data_out = '0;

    logic          src_ready, snk_valid, ovf, sdram_wr_req, sdram_rd_req;
    logic [DW-1:0] snk_data, sdram_data_in;
    logic [AW-1:0] sdram_wr_addr, sdram_rd_addr;
    logic [9:0]    wr_burst_len, rd_burst_len;
    logic [7:0]    stored_bursts;

    always #5 clk = ~clk;

    sdram_burst_master #(
        .BURST_LEN   (BL),
        .DATA_W      (DW),
        .ADDR_W      (AW),
        .FIFO_DEPTH  (DEPTH),
        .BASE_ADDR   (24'h000000),
        .SPAN_BURSTS (SPAN)
    ) dut (
        .sys_clk        (clk),
        .sys_rst        (rst),
        .init_end       (init_end),
        .src_valid      (src_valid),
        .src_data       (src_data),
        .src_ready      (src_ready),
        .rd_run         (rd_run),
        .snk_valid      (snk_valid),
        .snk_data       (snk_data),
        .ovf            (ovf),
        .sdram_wr_req   (sdram_wr_req),
        .sdram_wr_addr  (sdram_wr_addr),
        .wr_burst_len   (wr_burst_len),
        .sdram_data_in  (sdram_data_in),
        .sdram_wr_ack   (wr_ack),
        .sdram_rd_req   (sdram_rd_req),
        .sdram_rd_addr  (sdram_rd_addr),
        .rd_burst_len   (rd_burst_len),
        .sdram_data_out (sdram_data_out),
        .sdram_rd_ack   (rd_ack),
        .stored_bursts  (stored_bursts)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: FIFO contents, data awaiting read-back, burst progress per direction.
    logic [DW-1:0] fq[$];
    logic [DW-1:0] rq[$];
    logic          m_wr_req, m_rd_req, m_ovf, m_snk_valid;
    logic [DW-1:0] m_snk_data;
    int            m_wr_idx, m_rd_idx, m_stored, m_wr_acks, m_rd_acks;

    logic [DW-1:0] mem [int];
    logic [DW-1:0] got[$];
    byte           ev_kind[$];
    int            ev_addr[$];
    logic          prev_wr, prev_rd;

    int            src_left = 0;
    int            p_src = 100;
    int            p_ack = 100;
    bit            ack_en = 1'b0;
    logic [DW-1:0] next_word = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] rd_word(input int a);
        if (mem.exists(a)) return mem[a];
        return 16'hdead;
    endfunction

    task automatic model_reset();
        fq.delete(); rq.delete(); got.delete(); ev_kind.delete(); ev_addr.delete();
        m_wr_req = 0; m_rd_req = 0; m_ovf = 0; m_snk_valid = 0; m_snk_data = '0;
        m_wr_idx = 0; m_rd_idx = 0; m_stored = 0; m_wr_acks = 0; m_rd_acks = 0;
        prev_wr = 0; prev_rd = 0;
    endtask

    task automatic reset_checks();
        chk("rst_src_ready", src_ready, 1);
        chk("rst_ovf", ovf, 0);
        chk("rst_wr_req", sdram_wr_req, 0);
        chk("rst_rd_req", sdram_rd_req, 0);
        chk("rst_wr_addr", sdram_wr_addr, 0);
        chk("rst_rd_addr", sdram_rd_addr, 0);
        chk("rst_stored", stored_bursts, 0);
        chk("rst_snk_valid", snk_valid, 0);
        chk("rst_snk_data", snk_data, 0);
        chk("rst_data_in", sdram_data_in, 0);
        chk("rst_wr_len", wr_burst_len, BL);
        chk("rst_rd_len", rd_burst_len, BL);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        src_valid = 1'b0; wr_ack = 1'b0; rd_ack = 1'b0;
        #1;
        reset_checks();
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic compare();
        chk("src_ready", src_ready, fq.size() < DEPTH);
        chk("ovf", ovf, m_ovf);
        chk("wr_req", sdram_wr_req, m_wr_req);
        chk("rd_req", sdram_rd_req, m_rd_req);
        chk("wr_addr", sdram_wr_addr, m_wr_idx * BL);
        chk("rd_addr", sdram_rd_addr, m_rd_idx * BL);
        chk("stored", stored_bursts, m_stored);
        chk("data_in", sdram_data_in, (fq.size() > 0) ? fq[0] : 16'h0);
        chk("snk_valid", snk_valid, m_snk_valid);
        if (m_snk_valid) chk("snk_data", snk_data, m_snk_data);
        if (snk_valid) got.push_back(snk_data);
        if (sdram_wr_req && !prev_wr) begin ev_kind.push_back("W"); ev_addr.push_back(int'(sdram_wr_addr)); end
        if (sdram_rd_req && !prev_rd) begin ev_kind.push_back("R"); ev_addr.push_back(int'(sdram_rd_addr)); end
        prev_wr = sdram_wr_req;
        prev_rd = sdram_rd_req;
    endtask

    // One cycle: check outputs, drive inputs for the coming edge, advance the model across it.
    task automatic step();
        bit idle, push, pop, rack;
        int cnt_pre, st_pre;
        compare();
        src_valid = (src_left > 0) && ($urandom_range(99) < p_src);
        src_data  = next_word;
        if (src_valid) begin src_left--; next_word++; end
        wr_ack = ack_en && m_wr_req && ($urandom_range(99) < p_ack);
        rd_ack = ack_en && m_rd_req && ($urandom_range(99) < p_ack);
        if (wr_ack) mem[int'(sdram_wr_addr) + m_wr_acks] = sdram_data_in;
        sdram_data_out = rd_ack ? rd_word(int'(sdram_rd_addr) + m_rd_acks) : DW'($urandom);

        idle    = !m_wr_req && !m_rd_req;
        cnt_pre = fq.size();
        st_pre  = m_stored;
        push    = src_valid && (cnt_pre < DEPTH);
        pop     = m_wr_req && wr_ack;
        rack    = m_rd_req && rd_ack;
        if (src_valid && !push) m_ovf = 1'b1;
        m_snk_valid = rack;
        if (rack) m_snk_data = rq.pop_front();
        if (pop) rq.push_back(fq.pop_front());
        if (push) fq.push_back(src_data);
        if (pop) begin
            m_wr_acks++;
            if (m_wr_acks == BL) begin
                m_wr_acks = 0; m_wr_req = 0; m_stored++;
                m_wr_idx = (m_wr_idx + 1) % SPAN;
            end
        end
        if (rack) begin
            m_rd_acks++;
            if (m_rd_acks == BL) begin
                m_rd_acks = 0; m_rd_req = 0; m_stored--;
                m_rd_idx = (m_rd_idx + 1) % SPAN;
            end
        end
        if (idle && init_end) begin
            if (cnt_pre >= BL && st_pre < SPAN) m_wr_req = 1'b1;
            else if (rd_run && st_pre > 0)     m_rd_req = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic check_ev(input int idx, input byte kind, input int addr);
        if (idx >= ev_kind.size()) begin
            chk("ev_missing", idx, ev_kind.size());
        end else begin
            chk("ev_kind", ev_kind[idx], kind);
            chk("ev_addr", ev_addr[idx], addr);
        end
    endtask

    task automatic check_got(input int n);
        chk("got_count", got.size(), n);
        for (int i = 0; i < n && i < got.size(); i++) chk("got_word", got[i], i);
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset_checks();
        rst = 1'b0;

        // Single write burst of words 0..9.
        do_reset();
        init_end = 1; ack_en = 1; p_ack = 100; p_src = 100; next_word = 0; src_left = 10;
        run(40);
        chk("s1_stored", stored_bursts, 1);
        chk("s1_wr_req", sdram_wr_req, 0);
        check_ev(0, "W", 0);
        for (int i = 0; i < BL; i++) chk("s1_mem", rd_word(i), i);

        // Two writes then two reads, data returned in order.
        do_reset();
        next_word = 0; src_left = 20; rd_run = 0;
        run(25);
        rd_run = 1;
        run(100);
        check_ev(0, "W", 0); check_ev(1, "W", 10); check_ev(2, "R", 0); check_ev(3, "R", 10);
        check_got(20);
        rd_run = 0;

        // Overflow: 33 words with no controller activity.
        do_reset();
        init_end = 0; ack_en = 0; next_word = 0; src_left = 33;
        run(40);
        chk("s3_src_ready", src_ready, 0);
        chk("s3_ovf", ovf, 1);
        run(10);
        chk("s3_ovf_sticky", ovf, 1);

        // Region full holds the third write; it wraps to base after one read.
        do_reset();
        init_end = 1; ack_en = 1; next_word = 0; src_left = 30; rd_run = 0;
        run(100);
        chk("s4_stored", stored_bursts, 2);
        chk("s4_held", sdram_wr_req, 0);
        chk("s4_ev_count", ev_kind.size(), 2);
        rd_run = 1;
        run(150);
        check_ev(2, "R", 0); check_ev(3, "W", 0); check_ev(4, "R", 10); check_ev(5, "R", 0);
        check_got(30);
        rd_run = 0;

        // Reset after five acks of a write burst.
        do_reset();
        next_word = 0; src_left = 20;
        begin
            int n = 0;
            while (m_wr_acks != 5 && n < 200) begin step(); n++; end
            chk("s6_reach_5_acks", m_wr_acks, 5);
        end
        do_reset();
        next_word = 100; src_left = 10;
        run(60);
        check_ev(0, "W", 0);
        chk("s6_stored", stored_bursts, 1);
        chk("s6_mem0", rd_word(0), 100);

        // Random traffic.
        do_reset();
        ack_en = 1; p_src = 45; p_ack = 70; src_left = 1000000;
        for (int i = 0; i < 3000; i++) begin
            init_end = ($urandom_range(99) < 92);
            if (i % 40 == 0) rd_run = $urandom_range(1);
            if (i % 500 == 0) p_src = $urandom_range(20, 90);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
